// File: rtl/syscall_unit_pkg.sv
// rtl/syscall_unit_pkg.sv - service codes, FSM states and output-kind constants for syscall_unit
package syscall_unit_pkg;

   localparam logic [31:0] SYS_PRINT_INT = 32'd1;
   localparam logic [31:0] SYS_PRINT_STR = 32'd4;
   localparam logic [31:0] SYS_EXIT      = 32'd10;
   localparam logic [31:0] SYS_PRINT_CHR = 32'd11;

   localparam logic OUT_KIND_CHR = 1'b0;
   localparam logic OUT_KIND_INT = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_EMIT_INT = 3'd1,
      ST_EMIT_CHR = 3'd2,
      ST_FETCH    = 3'd3,
      ST_EMIT_STR = 3'd4,
      ST_HALT     = 3'd5
   } state_e;

endpackage

// File: rtl/syscall_unit.sv
// rtl/syscall_unit.sv - MIPS SYSCALL engine: print_int/char/string, exit; stalls the core while busy.
module syscall_unit
   import syscall_unit_pkg::*;
#(
   parameter int unsigned MAX_STR_LEN = 256
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        syscall,
   input  logic [31:0] v0,
   input  logic [31:0] a0,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        out_valid,
   output logic        out_kind,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic        stall,
   output logic        done,
   output logic        halted,
   output logic        err
);

   state_e      state_q, state_d;
   logic [31:0] ptr_q, ptr_d;
   logic [31:0] ptr_inc;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        out_valid_q, out_valid_d;
   logic        out_kind_q, out_kind_d;
   logic [31:0] out_data_q, out_data_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        halted_q, halted_d;
`ifdef SYSCALL_LEN_LIMIT_EN
   logic [31:0] cnt_q, cnt_d;
`endif

   assign ptr_inc = ptr_q + 32'd1;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      out_valid_d = out_valid_q;
      out_kind_d  = out_kind_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      halted_d    = halted_q;
`ifdef SYSCALL_LEN_LIMIT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (syscall) begin
               case (v0)
                  SYS_PRINT_INT: begin
                     state_d     = ST_EMIT_INT;
                     out_valid_d = 1'b1;
                     out_kind_d  = OUT_KIND_INT;
                     out_data_d  = a0;
                  end
                  SYS_PRINT_CHR: begin
                     state_d     = ST_EMIT_CHR;
                     out_valid_d = 1'b1;
                     out_kind_d  = OUT_KIND_CHR;
                     out_data_d  = {24'b0, a0[7:0]};
                  end
                  SYS_PRINT_STR: begin
                     state_d    = ST_FETCH;
                     ptr_d      = a0;
                     mem_req_d  = 1'b1;
                     mem_addr_d = a0;
`ifdef SYSCALL_LEN_LIMIT_EN
                     cnt_d      = 32'd0;
`endif
                  end
                  SYS_EXIT: begin
                     state_d  = ST_HALT;
                     halted_d = 1'b1;
                  end
                  default: begin
                     err_d  = 1'b1;
                     done_d = 1'b1;
                  end
               endcase
            end
         end
         ST_EMIT_INT, ST_EMIT_CHR: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               out_kind_d  = OUT_KIND_CHR;
               out_data_d  = 32'd0;
               done_d      = 1'b1;
            end
         end
         ST_FETCH: begin
            if (mem_ack) begin
               mem_req_d  = 1'b0;
               mem_addr_d = 32'd0;
               if (mem_rdata == 8'h00) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d     = ST_EMIT_STR;
                  out_valid_d = 1'b1;
                  out_kind_d  = OUT_KIND_CHR;
                  out_data_d  = {24'b0, mem_rdata};
               end
            end
         end
         ST_EMIT_STR: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_data_d  = 32'd0;
               ptr_d       = ptr_inc;
`ifdef SYSCALL_LEN_LIMIT_EN
               cnt_d       = cnt_q + 32'd1;
               if (cnt_q + 32'd1 == MAX_STR_LEN) begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  state_d    = ST_FETCH;
                  mem_req_d  = 1'b1;
                  mem_addr_d = ptr_inc;
               end
`else
               state_d    = ST_FETCH;
               mem_req_d  = 1'b1;
               mem_addr_d = ptr_inc;
`endif
            end
         end
         ST_HALT: begin
            halted_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= 32'd0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= 32'd0;
         out_valid_q <= 1'b0;
         out_kind_q  <= 1'b0;
         out_data_q  <= 32'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         halted_q    <= 1'b0;
`ifdef SYSCALL_LEN_LIMIT_EN
         cnt_q       <= 32'd0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         out_valid_q <= out_valid_d;
         out_kind_q  <= out_kind_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
         halted_q    <= halted_d;
`ifdef SYSCALL_LEN_LIMIT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign stall     = (syscall && (state_q == ST_IDLE)) || (state_q != ST_IDLE);
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign out_valid = out_valid_q;
   assign out_kind  = out_kind_q;
   assign out_data  = out_data_q;
   assign done      = done_q;
   assign err       = err_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_syscall_unit.sv
// tb/tb_syscall_unit.sv - scoreboard bench for syscall_unit
module tb_syscall_unit;

`ifdef SYSCALL_LEN_LIMIT_EN
   localparam int unsigned tb_max_str_len = 4;
`else
   localparam int unsigned tb_max_str_len = 256;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        syscall;
   logic [31:0] v0, a0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        out_valid, out_kind;
   logic [31:0] out_data;
   logic        out_ready;
   logic        stall, done, halted, err;

   typedef struct {
      logic        kind;
      logic [31:0] data;
   } item_t;

   item_t       sb_q[$];
   logic [31:0] addr_log[$];
   logic [7:0]  mem [0:511];

   int total_cnt = 0;
   int pass_cnt  = 0;
   int xfer_cnt  = 0;
   int done_cnt  = 0;
   int err_cnt   = 0;
   int req_cyc   = 0;
   int req_age   = 0;

   always #5 clk = ~clk;

   syscall_unit #(.MAX_STR_LEN(tb_max_str_len)) dut (
      .clk(clk), .reset(reset), .syscall(syscall), .v0(v0), .a0(a0),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_kind(out_kind), .out_data(out_data), .out_ready(out_ready),
      .stall(stall), .done(done), .halted(halted), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic push_item(input logic kind, input logic [31:0] data);
      item_t it;
      it.kind = kind;
      it.data = data;
      sb_q.push_back(it);
   endtask

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req && !reset) begin
            if (req_age == 0) addr_log.push_back(mem_addr);
            if (req_age == 1) begin
               mem_ack   = 1'b1;
               mem_rdata = mem[mem_addr[8:0]];
               req_age   = 0;
            end else begin
               req_age++;
            end
         end else begin
            req_age = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (mem_req) req_cyc++;
            if (out_valid && out_ready) begin
               xfer_cnt++;
               if (sb_q.size() == 0) begin
                  total_cnt++;
                  $display("FAIL sb_unexpected_output: got kind=%0d data=%h, expected no item", out_kind, out_data);
               end else begin
                  item_t e;
                  e = sb_q.pop_front();
                  chk("sb_out_kind", {31'b0, out_kind}, {31'b0, e.kind});
                  chk("sb_out_data", out_data, e.data);
               end
            end
         end
      end
   end

   task automatic issue(input logic [31:0] code, input logic [31:0] arg);
      syscall = 1'b1;
      v0      = code;
      a0      = arg;
      #1;
      chk("stall_on_issue", {31'b0, stall}, 32'd1);
      @(negedge clk);
      syscall = 1'b0;
      v0      = 32'd5;
      a0      = 32'h5555_AAAA;
   endtask

   task automatic wait_done(input string name, output logic saw_err);
      saw_err = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         #1;
         if (done) begin
            saw_err = err;
            chk({name, "_stall_at_done"}, {31'b0, stall}, 32'd0);
            return;
         end
      end
      total_cnt++;
      $display("FAIL %s_timeout: got no done, expected done within 80 cycles", name);
   endtask

   initial begin
      int   x0, r0, e0;
      logic se;
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      mem[9'h100] = 8'h48;
      mem[9'h101] = 8'h69;
      mem[9'h120] = 8'h41;
      mem[9'h121] = 8'h42;
      for (int i = 0; i < 6; i++) mem[9'h180 + i] = 8'h61 + 8'(i);

      reset = 1'b1; syscall = 1'b0; v0 = 32'd0; a0 = 32'd0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_kind", {31'b0, out_kind}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_flags", {28'b0, stall, done, halted, err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      push_item(1'b0, 32'h0000_0041);
      issue(32'd11, 32'hFFFF_FF41);
      #1;
      chk("chr_valid_c1", {31'b0, out_valid}, 32'd1);
      chk("chr_stall_c1", {31'b0, stall}, 32'd1);
      chk("chr_done_c1", {31'b0, done}, 32'd0);
      @(negedge clk); #1;
      chk("chr_done_c2", {31'b0, done}, 32'd1);
      chk("chr_stall_c2", {31'b0, stall}, 32'd0);
      chk("chr_valid_c2", {31'b0, out_valid}, 32'd0);
      @(negedge clk); #1;
      chk("chr_done_c3", {31'b0, done}, 32'd0);

      x0 = xfer_cnt;
      out_ready = 1'b0;
      push_item(1'b1, 32'hFFFF_FFFE);
      issue(32'd1, 32'hFFFF_FFFE);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("int_held_valid", {31'b0, out_valid}, 32'd1);
         chk("int_held_data", out_data, 32'hFFFF_FFFE);
         chk("int_held_kind", {31'b0, out_kind}, 32'd1);
         if (i < 2) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk); #1;
      chk("int_done", {31'b0, done}, 32'd1);
      @(negedge clk); #3;
      chk("int_xfer_once", xfer_cnt - x0, 32'd1);

      x0 = xfer_cnt;
      e0 = err_cnt;
      addr_log.delete();
      push_item(1'b0, 32'h48);
      push_item(1'b0, 32'h69);
      issue(32'd4, 32'h0000_0100);
      wait_done("str", se);
      chk("str_err", {31'b0, se}, 32'd0);
      @(negedge clk); #3;
      chk("str_xfers", xfer_cnt - x0, 32'd2);
      chk("str_req_count", addr_log.size(), 32'd3);
      if (addr_log.size() == 3) begin
         chk("str_addr0", addr_log[0], 32'h100);
         chk("str_addr1", addr_log[1], 32'h101);
         chk("str_addr2", addr_log[2], 32'h102);
      end
      chk("str_no_err_pulse", err_cnt - e0, 32'd0);

      x0 = xfer_cnt;
      r0 = req_cyc;
      issue(32'd7, 32'd0);
      #1;
      chk("bad_err", {31'b0, err}, 32'd1);
      chk("bad_done", {31'b0, done}, 32'd1);
      chk("bad_stall", {31'b0, stall}, 32'd0);
      @(negedge clk); #3;
      chk("bad_err_pulse", {31'b0, err}, 32'd0);
      chk("bad_no_out", xfer_cnt - x0, 32'd0);
      chk("bad_no_req", req_cyc - r0, 32'd0);

      out_ready = 1'b0;
      issue(32'd4, 32'h0000_0120);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      #1;
      chk("rstmid_in_emit", {31'b0, out_valid}, 32'd1);
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
      chk("rstmid_valid", {31'b0, out_valid}, 32'd0);
      chk("rstmid_stall", {31'b0, stall}, 32'd0);
      chk("rstmid_req", {31'b0, mem_req}, 32'd0);
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rstmid_stays_idle", {30'b0, out_valid, mem_req}, 32'd0);

`ifdef SYSCALL_LEN_LIMIT_EN
      x0 = xfer_cnt;
      for (int i = 0; i < 4; i++) push_item(1'b0, 32'h61 + i);
      issue(32'd4, 32'h0000_0180);
      wait_done("lim", se);
      chk("lim_err", {31'b0, se}, 32'd1);
      @(negedge clk); #3;
      chk("lim_xfers", xfer_cnt - x0, 32'd4);
`endif

      x0 = xfer_cnt;
      issue(32'd10, 32'd0);
      #1;
      chk("exit_halted", {31'b0, halted}, 32'd1);
      chk("exit_stall", {31'b0, stall}, 32'd1);
      @(negedge clk);
      issue(32'd11, 32'h42);
      repeat (4) @(negedge clk);
      #3;
      chk("exit_held", {30'b0, halted, stall}, 32'd3);
      chk("exit_no_out", xfer_cnt - x0, 32'd0);
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
      chk("exit_reset_clears", {30'b0, halted, stall}, 32'd0);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
